// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// No logic of its own; helpers are purely combinational.
// Carries no flow control.
package load_store_unit_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_REQ     = 2'd1,
    LSU_WAIT_RD = 2'd2
  } lsu_state_t;

  // RV32I width codes; loads and stores share 0..2
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] FAULT_LD_MISALIGN = 2'd0;
  localparam logic [1:0] FAULT_ST_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL     = 2'd2;

  // Operation latched at accept and held for the whole transaction
  typedef struct packed {
    logic              load;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] rd;
  } lsu_req_t;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the RAM only needs byte enables
  function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: shifts the addressed lane down and extends it.
// Purely combinational, zero latency.
// No flow control.
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Sign- or zero-extend the low byte/halfword; words pass through
  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per transaction against a single-port RAM.
// Request the cycle after accept; load write-back the cycle after the read response.
// oReady is low from accept until the transaction completes; faults keep it high.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic              iLoad,
  input  logic              iStore,
  input  logic [2:0]        iFunct3,
  input  logic [XLEN-1:0]   iAddr,
  input  logic [XLEN-1:0]   iWData,
  input  logic [REG_AW-1:0] iRd,
  output logic              oReady,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [XLEN-1:0]   oMemAddr,
  output logic [3:0]        oMemBe,
  output logic [XLEN-1:0]   oMemWData,
  input  logic              iMemGnt,
  input  logic              iMemRValid,
  input  logic [XLEN-1:0]   iMemRData,
  output logic              oRdValid,
  output logic [REG_AW-1:0] oRdAddr,
  output logic [XLEN-1:0]   oRdData,
  output logic              oFault,
  output logic [1:0]        oFaultCode
);

  lsu_state_t      state, state_nxt;
  lsu_req_t        req;
  logic            go;
  logic            capture;
  logic            fault_nxt;
  logic [1:0]      fault_code_nxt;
  logic            f3_legal;
  logic            misaligned;
  logic [XLEN-1:0] load_data;

  // Classify the incoming op: legal width code for its kind, natural alignment
  always_comb begin
    f3_legal = 1'b0;
    if (iLoad && !iStore) begin
      f3_legal = iFunct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end else if (iStore && !iLoad) begin
      f3_legal = iFunct3 inside {F3_B, F3_H, F3_W};
    end
    misaligned = ((iFunct3[1:0] == 2'd1) && iAddr[0]) ||
                 ((iFunct3[1:0] == 2'd2) && (iAddr[1:0] != 2'b00));
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge iClk) begin
    if (iRst) state <= LSU_IDLE;
    else      state <= state_nxt;
  end

  // Next-state, handshake and fault decode
  always_comb begin
    state_nxt      = state;
    oReady         = 1'b0;
    oMemReq        = 1'b0;
    go             = 1'b0;
    capture        = 1'b0;
    fault_nxt      = 1'b0;
    fault_code_nxt = 2'd0;
    case (state)
      LSU_IDLE: begin
        oReady = 1'b1;
        // Both kinds low is an accepted no-op; illegality outranks alignment
        if (iValid && (iLoad || iStore)) begin
          if (!f3_legal) begin
            fault_nxt      = 1'b1;
            fault_code_nxt = FAULT_ILLEGAL;
          end else if (misaligned) begin
            fault_nxt      = 1'b1;
            fault_code_nxt = iLoad ? FAULT_LD_MISALIGN : FAULT_ST_MISALIGN;
          end else begin
            go        = 1'b1;
            state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        oMemReq = 1'b1;
        if (iMemGnt) begin
          if (!req.load) begin
            state_nxt = LSU_IDLE;
          end else if (iMemRValid) begin
            capture   = 1'b1;
            state_nxt = LSU_IDLE;
          end else begin
            state_nxt = LSU_WAIT_RD;
          end
        end
      end
      LSU_WAIT_RD: begin
        if (iMemRValid) begin
          capture   = 1'b1;
          state_nxt = LSU_IDLE;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // Request fields come from the latched op so they stay stable until grant
  assign oMemWe    = oMemReq & ~req.load;
  assign oMemAddr  = oMemReq ? {req.addr[XLEN-1:2], 2'b00} : '0;
  assign oMemBe    = oMemReq ? store_be(req.funct3[1:0], req.addr[1:0]) : 4'b0000;
  assign oMemWData = oMemReq ? store_data(req.funct3[1:0], req.wdata) : '0;

  load_store_unit_load_align u_align (
    .rdata  (iMemRData),
    .funct3 (req.funct3),
    .offset (req.addr[1:0]),
    .data   (load_data)
  );

  // Latch the op at accept; register fault and write-back pulses
  always_ff @(posedge iClk) begin
    if (iRst) begin
      req        <= '0;
      oFault     <= 1'b0;
      oFaultCode <= 2'd0;
      oRdValid   <= 1'b0;
      oRdAddr    <= '0;
      oRdData    <= '0;
    end else begin
      oFault     <= fault_nxt;
      oFaultCode <= fault_code_nxt;
      // x0 is hardwired: the read still happens but nothing is written back
      oRdValid   <= capture && (req.rd != '0);
      if (go) begin
        req <= '{load: iLoad, funct3: iFunct3, addr: iAddr, wdata: iWData, rd: iRd};
      end
      if (capture) begin
        oRdAddr <= req.rd;
        oRdData <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops.
// Expected RAM requests, faults and write-backs come from a transaction-level model.
// RAM grant/response delays are randomized to exercise stalls.
module tb_load_store_unit;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0;
  logic        iLoad = 1'b0;
  logic        iStore = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iAddr = 32'd0;
  logic [31:0] iWData = 32'd0;
  logic [4:0]  iRd = 5'd0;
  logic        oReady, oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemGnt = 1'b0;
  logic        iMemRValid = 1'b0;
  logic [31:0] iMemRData = 32'd0;
  logic        oRdValid;
  logic [4:0]  oRdAddr;
  logic [31:0] oRdData;
  logic        oFault;
  logic [1:0]  oFaultCode;

  load_store_unit dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iLoad(iLoad), .iStore(iStore),
    .iFunct3(iFunct3), .iAddr(iAddr), .iWData(iWData), .iRd(iRd), .oReady(oReady),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWData(oMemWData), .iMemGnt(iMemGnt), .iMemRValid(iMemRValid),
    .iMemRData(iMemRData), .oRdValid(oRdValid), .oRdAddr(oRdAddr), .oRdData(oRdData),
    .oFault(oFault), .oFaultCode(oFaultCode)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [1:0]  exp_fault[$];
  logic [4:0]  exp_rd[$];
  logic [31:0] exp_rdata[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] last_addr, last_wdata, last_rd_data;
  logic [3:0]  last_be;
  logic        last_we;
  logic [4:0]  last_rd_addr;
  logic [1:0]  last_fault_code;
  int          req_cycles;

  logic [2:0] ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int size = m_size(f3);
    int off = int'(a % 4);
    return 4'(((1 << size) - 1) << off);
  endfunction

  // Lane k of the bus carries byte (k mod size) of the store data
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int size = m_size(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int bits = 8 * m_size(f3);
    v = longint'(rdata >> (8 * int'(a % 4)));
    if (bits < 32) begin
      v = v % (longint'(1) << bits);
      if (f3[2] == 1'b0 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    end
    return 32'(v);
  endfunction

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge iClk) begin
    if (!iRst) begin
      if (oMemReq) begin
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_req", 32'(oMemReq), 32'd0);
        end else begin
          chk("mem_addr", oMemAddr, exp_mem[0].addr);
          chk("mem_be", 32'(oMemBe), 32'(exp_mem[0].be));
          chk("mem_we", 32'(oMemWe), 32'(exp_mem[0].we));
          if (exp_mem[0].we) chk("mem_wdata", oMemWData, exp_mem[0].wdata);
          if (iMemGnt) void'(exp_mem.pop_front());
        end
      end
      if (oFault) begin
        if (exp_fault.size() == 0) begin
          chk("unexpected_fault", 32'(oFault), 32'd0);
        end else begin
          chk("fault_code", 32'(oFaultCode), 32'(exp_fault.pop_front()));
        end
      end
      if (oRdValid) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rd_valid", 32'(oRdValid), 32'd0);
        end else begin
          chk("rd_addr", 32'(oRdAddr), 32'(exp_rd.pop_front()));
          chk("rd_data", oRdData, exp_rdata.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(oReady), 32'd1);
    chk({tag, "_memreq"}, 32'(oMemReq), 32'd0);
    chk({tag, "_memwe"}, 32'(oMemWe), 32'd0);
    chk({tag, "_memaddr"}, oMemAddr, 32'd0);
    chk({tag, "_membe"}, 32'(oMemBe), 32'd0);
    chk({tag, "_memwdata"}, oMemWData, 32'd0);
    chk({tag, "_rdvalid"}, 32'(oRdValid), 32'd0);
    chk({tag, "_rdaddr"}, 32'(oRdAddr), 32'd0);
    chk({tag, "_rddata"}, oRdData, 32'd0);
    chk({tag, "_fault"}, 32'(oFault), 32'd0);
    chk({tag, "_faultcode"}, 32'(oFaultCode), 32'd0);
  endtask

  // One complete transaction: accept, RAM handshake with given delays, completion
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int gdly, input int rdly,
                       input logic [31:0] rdata);
    int n;
    bit illegal, mis, fault, legal;
    mem_exp_t m;
    @(posedge iClk); #1;
    n = 0;
    while (!oReady && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    if (!oReady) begin
      chk("ready_timeout", 32'(oReady), 32'd1);
      return;
    end
    iValid = 1'b1; iLoad = ld; iStore = st; iFunct3 = f3; iAddr = addr; iWData = wd; iRd = rd;

    illegal = (ld && st) ||
              (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (st && !(f3 inside {3'd0, 3'd1, 3'd2}));
    mis     = (addr % m_size(f3)) != 0;
    fault   = (ld || st) && (illegal || mis);
    legal   = (ld || st) && !fault;
    if (fault) exp_fault.push_back(illegal ? 2'd2 : (ld ? 2'd0 : 2'd1));
    if (legal) begin
      m.addr = {addr[31:2], 2'b00};
      m.be = m_be(f3, addr);
      m.wdata = m_wdata(f3, wd);
      m.we = st;
      exp_mem.push_back(m);
      if (ld && rd != 5'd0) begin
        exp_rd.push_back(rd);
        exp_rdata.push_back(m_load(rdata, f3, addr));
      end
    end

    @(posedge iClk); #1;
    // Scramble the op inputs once accepted: the unit must work from its latched copy
    iValid = 1'b0; iLoad = 1'($urandom_range(0, 1)); iStore = 1'($urandom_range(0, 1));
    iFunct3 = 3'($urandom_range(0, 7)); iAddr = $urandom; iWData = $urandom; iRd = 5'($urandom_range(0, 31));

    if (!legal) begin
      @(negedge iClk);
      chk("fault_pulse", 32'(oFault), 32'(fault));
      chk("fault_no_req", 32'(oMemReq), 32'd0);
      chk("fault_ready", 32'(oReady), 32'd1);
      last_fault_code = oFaultCode;
      return;
    end

    req_cycles = 0;
    for (int c = 0; c <= gdly; c++) begin
      iMemGnt = (c == gdly);
      iMemRValid = ld ? (c == gdly && rdly == 0) : 1'($urandom_range(0, 1));
      iMemRData = (ld && c == gdly && rdly == 0) ? rdata : $urandom;
      @(negedge iClk);
      if (oMemReq) req_cycles++;
      if (c == 0) begin
        chk("req_after_accept", 32'(oMemReq), 32'd1);
        chk("busy_not_ready", 32'(oReady), 32'd0);
        last_addr = oMemAddr; last_be = oMemBe; last_wdata = oMemWData; last_we = oMemWe;
      end
      @(posedge iClk); #1;
    end
    iMemGnt = 1'b0; iMemRValid = 1'b0;
    if (ld && rdly > 0) begin
      for (int c = 1; c <= rdly; c++) begin
        iMemRValid = (c == rdly);
        iMemRData = (c == rdly) ? rdata : $urandom;
        iMemGnt = 1'($urandom_range(0, 1));
        @(negedge iClk);
        if (c == 1) chk("wait_no_req", 32'(oMemReq), 32'd0);
        @(posedge iClk); #1;
      end
      iMemRValid = 1'b0; iMemGnt = 1'b0;
    end
    @(negedge iClk);
    chk("wb_pulse", 32'(oRdValid), 32'(ld && rd != 5'd0));
    chk("idle_after", 32'(oReady), 32'd1);
    last_rd_addr = oRdAddr; last_rd_data = oRdData;
  endtask

  // Load aborted by reset while waiting for data; the late response must be dropped
  task automatic reset_mid_load();
    mem_exp_t m;
    @(posedge iClk); #1;
    iValid = 1'b1; iLoad = 1'b1; iStore = 1'b0; iFunct3 = 3'd2; iAddr = 32'h80; iRd = 5'd4;
    m.addr = 32'h80; m.be = 4'hF; m.wdata = 32'd0; m.we = 1'b0;
    exp_mem.push_back(m);
    @(posedge iClk); #1;
    iValid = 1'b0; iLoad = 1'b0;
    iMemGnt = 1'b1;
    @(posedge iClk); #1;
    iMemGnt = 1'b0;
    @(negedge iClk);
    chk("wait_rd_not_ready", 32'(oReady), 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    iMemRValid = 1'b1; iMemRData = 32'hCAFEF00D;
    @(negedge iClk);
    chk_reset_outputs("abort");
    @(posedge iClk); #1;
    iMemRValid = 1'b0;
    @(negedge iClk);
    chk("late_resp_dropped", 32'(oRdValid), 32'd0);
    chk("abort_ready", 32'(oReady), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, st;
    int k, sz;
    logic [2:0] f3;
    logic [31:0] a;
    logic [4:0] rd;

    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk_reset_outputs("reset");
    @(posedge iClk); #1;
    iRst = 1'b0;

    // SW with a two-cycle grant stall
    do_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 2, 0, 32'd0);
    chk("sw_addr", last_addr, 32'h100);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_we", 32'(last_we), 32'd1);
    chk("sw_req_cycles", 32'(req_cycles), 32'd3);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);

    // SB to the top lane
    do_op(1'b0, 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd0, 0, 0, 32'd0);
    chk("sb_addr", last_addr, 32'h200);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);

    // Sub-word loads from offset 2
    do_op(1'b1, 1'b0, 3'd0, 32'h102, 32'd0, 5'd3, 1, 1, 32'h0080FF11);
    chk("lb_data", last_rd_data, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 5'd3, 0, 2, 32'h0080FF11);
    chk("lbu_data", last_rd_data, 32'h00000080);
    do_op(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 5'd3, 0, 0, 32'h0080FF11);
    chk("lh_data", last_rd_data, 32'h00000080);
    chk("lh_be", 32'(last_be), 32'hC);

    // Faults: misaligned load, misaligned store, illegal funct3, load+store
    do_op(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 5'd5, 0, 0, 32'd0);
    chk("lw_mis_code", 32'(last_fault_code), 32'd0);
    do_op(1'b0, 1'b1, 3'd1, 32'h201, 32'h1234, 5'd0, 0, 0, 32'd0);
    chk("sh_mis_code", 32'(last_fault_code), 32'd1);
    do_op(1'b1, 1'b0, 3'd3, 32'h200, 32'd0, 5'd5, 0, 0, 32'd0);
    chk("ld_illegal_code", 32'(last_fault_code), 32'd2);
    do_op(1'b1, 1'b1, 3'd2, 32'h200, 32'd0, 5'd5, 0, 0, 32'd0);
    chk("ldst_illegal_code", 32'(last_fault_code), 32'd2);

    // Minimum-latency load, then the same into x0
    do_op(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 5'd7, 0, 0, 32'h11223344);
    chk("fast_rd_addr", 32'(last_rd_addr), 32'd7);
    chk("fast_rd_data", last_rd_data, 32'h11223344);
    do_op(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 5'd0, 0, 0, 32'h55667788);

    reset_mid_load();
    do_op(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, 5'd9, 1, 2, 32'h12345678);
    chk("post_reset_load", last_rd_data, 32'h12345678);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 99);
      ld = (k < 45) || (k >= 95);
      st = (k >= 45 && k < 85) || (k >= 95);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) f3 = ld_f3s[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        sz = m_size(f3);
        a = a - (a % sz);
      end
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(ld, st, f3, a, $urandom, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    @(posedge iClk); #1;
    @(negedge iClk);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    chk("fault_queue_drained", 32'(exp_fault.size()), 32'd0);
    chk("wb_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
